// File: rtl/hist_peak_stats_if.sv
// Bin-count input stream and result-byte output stream of hist_peak_stats.
// The slave modport is the block; the master modport is the surrounding logic that drives it.
interface hist_peak_stats_if;
  logic [7:0] count_in;
  logic       count_valid;
  logic       count_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  modport slave (
    input  count_in, count_valid, count_last, out_ready,
    output out_data, out_valid, out_last, busy
  );

  modport master (
    output count_in, count_valid, count_last, out_ready,
    input  out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/hist_peak_stats.sv
// Per-frame peak/sum tracker over a histogram bin-count stream.
// At the end of each frame it emits a 5-byte record over a valid/ready byte port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_ACCUM | absorbing bin counts, updating peak, sum and index
// ST_EMIT  | presenting record byte byte_sel_q, input beats dropped
module hist_peak_stats (
  input  logic             clk,
  input  logic             rst_n,
  hist_peak_stats_if.slave bus
);

  typedef enum logic {ST_ACCUM = 1'b0, ST_EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  peak_idx_q, peak_idx_d;
  logic [7:0]  peak_cnt_q, peak_cnt_d;
  logic [15:0] sum_q, sum_d;
  logic        idx_ovf_q, idx_ovf_d;
  logic        sum_sat_q, sum_sat_d;
  logic [2:0]  byte_sel_q, byte_sel_d;

  logic [16:0] sum_ext;
  logic        handshake;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      idx_q      <= 8'd0;
      peak_idx_q <= 8'd0;
      peak_cnt_q <= 8'd0;
      sum_q      <= 16'd0;
      idx_ovf_q  <= 1'b0;
      sum_sat_q  <= 1'b0;
      byte_sel_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      peak_idx_q <= peak_idx_d;
      peak_cnt_q <= peak_cnt_d;
      sum_q      <= sum_d;
      idx_ovf_q  <= idx_ovf_d;
      sum_sat_q  <= sum_sat_d;
      byte_sel_q <= byte_sel_d;
    end
  end

  assign handshake = (state_q == ST_EMIT) && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    peak_idx_d = peak_idx_q;
    peak_cnt_d = peak_cnt_q;
    sum_d      = sum_q;
    idx_ovf_d  = idx_ovf_q;
    sum_sat_d  = sum_sat_q;
    byte_sel_d = byte_sel_q;
    sum_ext    = {1'b0, sum_q} + {9'd0, bus.count_in};

    case (state_q)
      ST_ACCUM: begin
        if (bus.count_valid) begin
          if (sum_ext[16]) begin
            sum_d     = 16'hFFFF;
            sum_sat_d = 1'b1;
          end else begin
            sum_d = sum_ext[15:0];
          end
          // Strict compare so ties keep the earliest bin.
          if (bus.count_in > peak_cnt_q) begin
            peak_cnt_d = bus.count_in;
            peak_idx_d = idx_q;
          end
          if (idx_q == 8'hFF) begin
            idx_ovf_d = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
          if (bus.count_last) begin
            state_d    = ST_EMIT;
            byte_sel_d = 3'd0;
          end
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          if (byte_sel_q == 3'd4) begin
            state_d    = ST_ACCUM;
            idx_d      = 8'd0;
            peak_idx_d = 8'd0;
            peak_cnt_d = 8'd0;
            sum_d      = 16'd0;
            idx_ovf_d  = 1'b0;
            sum_sat_d  = 1'b0;
            byte_sel_d = 3'd0;
          end else begin
            byte_sel_d = byte_sel_q + 3'd1;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (state_q == ST_EMIT) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (byte_sel_q == 3'd4);
      case (byte_sel_q)
        3'd0:    out_data = peak_idx_q;
        3'd1:    out_data = peak_cnt_q;
        3'd2:    out_data = sum_q[15:8];
        3'd3:    out_data = sum_q[7:0];
        default: out_data = {6'b0, sum_sat_q, idx_ovf_q};
      endcase
    end
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_hist_peak_stats.sv
// Directed-vector bench for hist_peak_stats: frame records, ties, backpressure,
// overflow/saturation, reset mid-emit and beats dropped during emit.
module tb_hist_peak_stats;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  hist_peak_stats_if bus ();

  hist_peak_stats dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one input beat for exactly one edge; returns 1 time unit after that edge.
  task automatic send_beat(input logic [7:0] c, input logic last);
    bus.count_in    = c;
    bus.count_valid = 1'b1;
    bus.count_last  = last;
    @(posedge clk);
    #1;
    bus.count_valid = 1'b0;
    bus.count_last  = 1'b0;
    bus.count_in    = 8'h00;
  endtask

  // Collects up to 5 handshaken bytes. ready_pat bit i is out_ready in cycle i
  // (cycles beyond pat_len use ready=1). With junk set, 0x80 beats are pushed
  // every cycle. Returns 1 time unit after the B4 handshake edge.
  task automatic recv_record(input logic [15:0] ready_pat, input int pat_len,
                             input bit junk,
                             output logic [39:0] rec, output logic [4:0] lastv,
                             output int got, output bit stable);
    logic [7:0] prev_data;
    bit         prev_stall;
    rec        = 40'd0;
    lastv      = 5'd0;
    got        = 0;
    stable     = 1'b1;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      bus.out_ready = (cyc < pat_len) ? ready_pat[cyc] : 1'b1;
      if (junk) begin
        bus.count_valid = 1'b1;
        bus.count_in    = 8'h80;
        bus.count_last  = (cyc == 2);
      end
      #4;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stable = 1'b0;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        rec   = {rec[31:0], bus.out_data};
        lastv = {lastv[3:0], bus.out_last};
        got++;
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready   = 1'b0;
    bus.count_valid = 1'b0;
    bus.count_last  = 1'b0;
    bus.count_in    = 8'h00;
  endtask

  task automatic check_record(input string name, input logic [39:0] rec,
                              input logic [4:0] lastv, input int got,
                              input logic [39:0] exp_rec);
    vectors++;
    if (got !== 5) begin
      miscompares++;
      $display("FAIL %s byte_count got %0d want 5", name, got);
    end
    vectors++;
    if (rec !== exp_rec) begin
      miscompares++;
      $display("FAIL %s record got %h want %h", name, rec, exp_rec);
    end
    vectors++;
    if (lastv !== 5'b00001) begin
      miscompares++;
      $display("FAIL %s out_last got %b want 00001", name, lastv);
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.count_in    = 8'h00;
    bus.count_valid = 1'b0;
    bus.count_last  = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    vectors++;
    if (bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_last got %b want 0", bus.out_last);
    end
    vectors++;
    if (bus.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out_data got %h want 00", bus.out_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_16bin(input logic [15:0] ready_pat, input int pat_len,
                            input string name);
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    for (int i = 0; i < 15; i++) send_beat(8'(i), 1'b0);
    bus.count_in    = 8'd15;
    bus.count_valid = 1'b1;
    bus.count_last  = 1'b1;
    #3;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_valid got %b want 0", name, bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.count_valid = 1'b0;
    bus.count_last  = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s valid_busy_after_last got %b%b want 11", name,
               bus.out_valid, bus.busy);
    end
    vectors++;
    if (bus.out_data !== 8'h0F) begin
      miscompares++;
      $display("FAIL %s first_byte got %h want 0f", name, bus.out_data);
    end
    recv_record(ready_pat, pat_len, 1'b0, rec, lastv, got, stable);
    check_record(name, rec, lastv, got, 40'h0F_0F_00_78_00);
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL %s stall_stability got unstable want stable", name);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after_b4 got busy=%b valid=%b want 0 0", name,
               bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_tie();
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    send_beat(8'd5, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd2, 1'b1);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("tie", rec, lastv, got, 40'h01_09_00_19_00);
  endtask

  task automatic test_overflow();
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    for (int i = 1; i <= 300; i++) send_beat(8'hFF, i == 300);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("overflow", rec, lastv, got, 40'h00_FF_FF_FF_03);
  endtask

  task automatic test_reset_mid_emit();
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    send_beat(8'd7, 1'b0);
    send_beat(8'd3, 1'b1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_data !== 8'h00 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_emit_b2 got valid=%b data=%h want 1 00", bus.out_valid,
               bus.out_data);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_emit_reset got valid=%b busy=%b data=%h want 0 0 00",
               bus.out_valid, bus.busy, bus.out_data);
    end
    send_beat(8'h2A, 1'b1);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("after_reset", rec, lastv, got, 40'h00_2A_00_2A_00);
  endtask

  task automatic test_dropped_beats();
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    send_beat(8'd4, 1'b0);
    send_beat(8'd6, 1'b1);
    recv_record(16'b0_0101, 5, 1'b1, rec, lastv, got, stable);
    check_record("junk_frame", rec, lastv, got, 40'h01_06_00_0A_00);
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b1);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("after_junk", rec, lastv, got, 40'h01_02_00_03_00);
  endtask

  task automatic test_back_to_back();
    logic [39:0] rec;
    logic [4:0]  lastv;
    int          got;
    bit          stable;
    send_beat(8'd0, 1'b1);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("zero_frame", rec, lastv, got, 40'h00_00_00_00_00);
    send_beat(8'd3, 1'b0);
    send_beat(8'd200, 1'b0);
    send_beat(8'd100, 1'b1);
    recv_record(16'h0, 0, 1'b0, rec, lastv, got, stable);
    check_record("b2b_frame", rec, lastv, got, 40'h01_C8_01_2F_00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_16bin(16'h0, 0, "bins16");
    test_tie();
    // ready: 0,0,0 then 1-0-1-1-0-1 (bit i = cycle i)
    test_16bin(16'b1_0110_1000, 9, "backpressure");
    test_overflow();
    test_reset_mid_emit();
    test_dropped_beats();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
